// File: rtl/ex_pkg.sv
// Shared definitions for the multi-cycle execute stage: op codes, FSM states,
// and the EX/MEM write selector used by the top-level sequencer.
package ex_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_LSL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    typedef enum logic [1:0] {
        WR_HOLD   = 2'd0,
        WR_BUBBLE = 2'd1,
        WR_BUNDLE = 2'd2,
        WR_RESULT = 2'd3
    } p3_wr_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per step; product
// shows the accumulator including the current step so the last step is usable directly.
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  logic            clear,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = (cnt == CW'(XLEN - 1));

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with inline forwarding muxes and ALU, plus a two-state
// sequencer that stalls upstream while the iterative multiplier runs.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RIDX = 3,
    parameter int SDW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p3_pipeline_regWrite,
    input  logic            EX_flush,
    input  logic            in_valid,
    input  logic [3:0]      p2_aluOp,
    input  logic            p2_aluSrcB,
    input  logic            p2_memRead,
    input  logic            p2_memWrite,
    input  logic [RIDX-1:0] p2_alu_rd,
    input  logic [RIDX-1:0] p2_mem_rd,
    input  logic [XLEN-1:0] p2_alu_reg_rn,
    input  logic [XLEN-1:0] p2_alu_reg_rm,
    input  logic [XLEN-1:0] p2_alu_imm,
    input  logic [XLEN-1:0] p2_mem_reg_rn,
    input  logic [XLEN-1:0] p2_mem_reg_rd,
    input  logic [XLEN-1:0] p2_mem_imm,
    input  logic [XLEN-1:0] fwd_1,
    input  logic [XLEN-1:0] fwd_2,
    input  logic [XLEN-1:0] fwd_3,
    input  logic [1:0]      f_alu_rn_sel,
    input  logic [1:0]      f_alu_rm_sel,
    input  logic [1:0]      f_mem_rn_sel,
    input  logic [1:0]      f_mem_rd_sel,
    output logic            ex_stall,
    output logic            p3_valid,
    output logic            p3_memRead,
    output logic            p3_memWrite,
    output logic [RIDX-1:0] p3_alu_rd,
    output logic [RIDX-1:0] p3_mem_rd,
    output logic [SDW-1:0]  p3_mem_reg_rd,
    output logic [XLEN-1:0] p3_alu_aluOut,
    output logic [XLEN-1:0] p3_mem_address,
    output logic            p3_flag_z,
    output logic            p3_flag_n,
    output logic            p3_flag_c,
    output logic            p3_flag_v
);
    localparam int SHW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] f1, input logic [XLEN-1:0] f2,
                                                 input logic [XLEN-1:0] f3);
        case (sel)
            2'd1:    return f1;
            2'd2:    return f2;
            2'd3:    return f3;
            default: return r;
        endcase
    endfunction

    logic [XLEN-1:0] alu_rn, alu_rm, alu_b, mem_rn, mem_addr;
    logic [SDW-1:0]  mem_st_data;
    logic [XLEN:0]   add_w, sub_w;
    logic [XLEN-1:0] alu_res;
    logic            alu_c, alu_v;

    assign alu_rn      = fwd_mux(f_alu_rn_sel, p2_alu_reg_rn, fwd_1, fwd_2, fwd_3);
    assign alu_rm      = fwd_mux(f_alu_rm_sel, p2_alu_reg_rm, fwd_1, fwd_2, fwd_3);
    assign mem_rn      = fwd_mux(f_mem_rn_sel, p2_mem_reg_rn, fwd_1, fwd_2, fwd_3);
    assign mem_st_data = SDW'(fwd_mux(f_mem_rd_sel, p2_mem_reg_rd, fwd_1, fwd_2, fwd_3));
    assign alu_b       = p2_aluSrcB ? p2_alu_imm : alu_rm;
    assign mem_addr    = mem_rn + p2_mem_imm;

    // Subtract as rn + ~b + 1 so the carry out is the no-borrow flag.
    assign add_w = {1'b0, alu_rn} + {1'b0, alu_b};
    assign sub_w = {1'b0, alu_rn} + {1'b0, ~alu_b} + {{XLEN{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (p2_aluOp)
            OP_ADD: begin
                alu_res = add_w[XLEN-1:0];
                alu_c   = add_w[XLEN];
                alu_v   = (alu_rn[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_rn[XLEN-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[XLEN-1:0];
                alu_c   = sub_w[XLEN];
                alu_v   = (alu_rn[XLEN-1] != alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_rn[XLEN-1]);
            end
            OP_AND:  alu_res = alu_rn & alu_b;
            OP_ORR:  alu_res = alu_rn | alu_b;
            OP_EOR:  alu_res = alu_rn ^ alu_b;
            OP_LSL:  alu_res = alu_rn << alu_b[SHW-1:0];
            OP_LSR:  alu_res = alu_rn >> alu_b[SHW-1:0];
            OP_MOV:  alu_res = alu_b;
            default: alu_res = '0;
        endcase
    end

    ex_state_e       state_q, state_d;
    p3_wr_e          wr_sel;
    logic            mul_start, mul_step, mul_done;
    logic [XLEN-1:0] mul_product;

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .step    (mul_step),
        .clear   (EX_flush),
        .a       (alu_rn),
        .b       (alu_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        wr_sel    = WR_HOLD;
        if (EX_flush) begin
            state_d = ST_IDLE;
            wr_sel  = WR_BUBBLE;
        end else if (p3_pipeline_regWrite) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && p2_aluOp == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                        wr_sel    = WR_BUBBLE;
                    end else begin
                        wr_sel = WR_BUNDLE;
                    end
                end
                ST_MUL: begin
                    mul_step = 1'b1;
                    if (mul_done) begin
                        state_d = ST_IDLE;
                        wr_sel  = WR_RESULT;
                    end else begin
                        wr_sel = WR_BUBBLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ex_stall = !reset && (mul_start || (state_q == ST_MUL && !mul_done));

    // MEM lane of an accepted MUL is parked here until the product is ready.
    logic            cap_memRead, cap_memWrite;
    logic [RIDX-1:0] cap_alu_rd, cap_mem_rd;
    logic [SDW-1:0]  cap_mem_reg_rd;
    logic [XLEN-1:0] cap_mem_address;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_memRead     <= 1'b0;
            cap_memWrite    <= 1'b0;
            cap_alu_rd      <= '0;
            cap_mem_rd      <= '0;
            cap_mem_reg_rd  <= '0;
            cap_mem_address <= '0;
        end else if (mul_start) begin
            cap_memRead     <= p2_memRead;
            cap_memWrite    <= p2_memWrite;
            cap_alu_rd      <= p2_alu_rd;
            cap_mem_rd      <= p2_mem_rd;
            cap_mem_reg_rd  <= mem_st_data;
            cap_mem_address <= mem_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p3_valid       <= 1'b0;
            p3_memRead     <= 1'b0;
            p3_memWrite    <= 1'b0;
            p3_alu_rd      <= '0;
            p3_mem_rd      <= '0;
            p3_mem_reg_rd  <= '0;
            p3_alu_aluOut  <= '0;
            p3_mem_address <= '0;
            p3_flag_z      <= 1'b0;
            p3_flag_n      <= 1'b0;
            p3_flag_c      <= 1'b0;
            p3_flag_v      <= 1'b0;
        end else begin
            case (wr_sel)
                WR_BUBBLE: begin
                    p3_valid    <= 1'b0;
                    p3_memRead  <= 1'b0;
                    p3_memWrite <= 1'b0;
                end
                WR_BUNDLE: begin
                    p3_valid       <= in_valid;
                    p3_memRead     <= p2_memRead & in_valid;
                    p3_memWrite    <= p2_memWrite & in_valid;
                    p3_alu_rd      <= p2_alu_rd;
                    p3_mem_rd      <= p2_mem_rd;
                    p3_mem_reg_rd  <= mem_st_data;
                    p3_alu_aluOut  <= alu_res;
                    p3_mem_address <= mem_addr;
                    p3_flag_z      <= (alu_res == '0);
                    p3_flag_n      <= alu_res[XLEN-1];
                    p3_flag_c      <= alu_c;
                    p3_flag_v      <= alu_v;
                end
                WR_RESULT: begin
                    p3_valid       <= 1'b1;
                    p3_memRead     <= cap_memRead;
                    p3_memWrite    <= cap_memWrite;
                    p3_alu_rd      <= cap_alu_rd;
                    p3_mem_rd      <= cap_mem_rd;
                    p3_mem_reg_rd  <= cap_mem_reg_rd;
                    p3_alu_aluOut  <= mul_product;
                    p3_mem_address <= cap_mem_address;
                    p3_flag_z      <= (mul_product == '0);
                    p3_flag_n      <= mul_product[XLEN-1];
                    p3_flag_c      <= 1'b0;
                    p3_flag_v      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: randomized bundles against an
// arithmetic reference model, plus directed MUL, flush, hold and reset scenarios.
module tb_ex_stage_mc;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        p3_pipeline_regWrite, EX_flush, in_valid;
    logic [3:0]  p2_aluOp;
    logic        p2_aluSrcB, p2_memRead, p2_memWrite;
    logic [2:0]  p2_alu_rd, p2_mem_rd;
    logic [31:0] p2_alu_reg_rn, p2_alu_reg_rm, p2_alu_imm;
    logic [31:0] p2_mem_reg_rn, p2_mem_reg_rd, p2_mem_imm;
    logic [31:0] fwd_1, fwd_2, fwd_3;
    logic [1:0]  f_alu_rn_sel, f_alu_rm_sel, f_mem_rn_sel, f_mem_rd_sel;
    logic        ex_stall, p3_valid, p3_memRead, p3_memWrite;
    logic [2:0]  p3_alu_rd, p3_mem_rd;
    logic [7:0]  p3_mem_reg_rd;
    logic [31:0] p3_alu_aluOut, p3_mem_address;
    logic        p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        valid, mr, mw;
        logic [2:0]  ard, mrd;
        logic [7:0]  mreg;
        logic [31:0] out, addr;
        logic        z, n, c, v;
    } exp_t;

    ex_stage_mc dut (
        .clk(clk), .reset(reset),
        .p3_pipeline_regWrite(p3_pipeline_regWrite), .EX_flush(EX_flush), .in_valid(in_valid),
        .p2_aluOp(p2_aluOp), .p2_aluSrcB(p2_aluSrcB), .p2_memRead(p2_memRead), .p2_memWrite(p2_memWrite),
        .p2_alu_rd(p2_alu_rd), .p2_mem_rd(p2_mem_rd),
        .p2_alu_reg_rn(p2_alu_reg_rn), .p2_alu_reg_rm(p2_alu_reg_rm), .p2_alu_imm(p2_alu_imm),
        .p2_mem_reg_rn(p2_mem_reg_rn), .p2_mem_reg_rd(p2_mem_reg_rd), .p2_mem_imm(p2_mem_imm),
        .fwd_1(fwd_1), .fwd_2(fwd_2), .fwd_3(fwd_3),
        .f_alu_rn_sel(f_alu_rn_sel), .f_alu_rm_sel(f_alu_rm_sel),
        .f_mem_rn_sel(f_mem_rn_sel), .f_mem_rd_sel(f_mem_rd_sel),
        .ex_stall(ex_stall), .p3_valid(p3_valid), .p3_memRead(p3_memRead), .p3_memWrite(p3_memWrite),
        .p3_alu_rd(p3_alu_rd), .p3_mem_rd(p3_mem_rd), .p3_mem_reg_rd(p3_mem_reg_rd),
        .p3_alu_aluOut(p3_alu_aluOut), .p3_mem_address(p3_mem_address),
        .p3_flag_z(p3_flag_z), .p3_flag_n(p3_flag_n), .p3_flag_c(p3_flag_c), .p3_flag_v(p3_flag_v)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t observed();
        exp_t o;
        o = '{p3_valid, p3_memRead, p3_memWrite, p3_alu_rd, p3_mem_rd, p3_mem_reg_rd,
              p3_alu_aluOut, p3_mem_address, p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v};
        return o;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
        if (sel == 2'd1) return fwd_1;
        if (sel == 2'd2) return fwd_2;
        if (sel == 2'd3) return fwd_3;
        return r;
    endfunction

    // Reference: what EX/MEM must hold once the bundle currently on the inputs completes.
    function automatic exp_t model_bundle();
        exp_t m;
        logic [31:0] a, b, r;
        longint ua, ub, sa, sb, t;
        longint smax, smin;
        smax = 2147483647;
        smin = -smax - 1;
        a  = pick(f_alu_rn_sel, p2_alu_reg_rn);
        b  = p2_aluSrcB ? p2_alu_imm : pick(f_alu_rm_sel, p2_alu_reg_rm);
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = $signed(a);
        sb = $signed(b);
        m  = '0;
        case (p2_aluOp)
            4'd0: begin r = 32'(ua + ub); m.c = (ua + ub) > 64'hFFFF_FFFF; t = sa + sb; m.v = (t > smax) || (t < smin); end
            4'd1: begin r = 32'(ua - ub); m.c = (ua >= ub); t = sa - sb; m.v = (t > smax) || (t < smin); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = 32'(ua * (64'd1 << b[4:0]));
            4'd6: r = 32'(ua / (64'd1 << b[4:0]));
            4'd7: r = b;
            4'd8: r = 32'(ua * ub);
            default: r = 32'd0;
        endcase
        m.out   = r;
        m.z     = (r == 32'd0);
        m.n     = r[31];
        m.valid = in_valid;
        m.mr    = p2_memRead & in_valid;
        m.mw    = p2_memWrite & in_valid;
        m.ard   = p2_alu_rd;
        m.mrd   = p2_mem_rd;
        m.mreg  = 8'(pick(f_mem_rd_sel, p2_mem_reg_rd));
        m.addr  = pick(f_mem_rn_sel, p2_mem_reg_rn) + p2_mem_imm;
        return m;
    endfunction

    task automatic rand_bundle(input logic [3:0] op, input logic v);
        in_valid      = v;
        p2_aluOp      = op;
        p2_aluSrcB    = 1'($urandom);
        p2_memRead    = 1'($urandom);
        p2_memWrite   = 1'($urandom);
        p2_alu_rd     = 3'($urandom);
        p2_mem_rd     = 3'($urandom);
        p2_alu_reg_rn = $urandom;
        p2_alu_reg_rm = $urandom;
        p2_alu_imm    = $urandom;
        p2_mem_reg_rn = $urandom;
        p2_mem_reg_rd = $urandom;
        p2_mem_imm    = $urandom;
        fwd_1         = $urandom;
        fwd_2         = $urandom;
        fwd_3         = $urandom;
        f_alu_rn_sel  = 2'($urandom);
        f_alu_rm_sel  = 2'($urandom);
        f_mem_rn_sel  = 2'($urandom);
        f_mem_rd_sel  = 2'($urandom);
    endtask

    task automatic test_reset();
        exp_t got;
        rand_bundle(OP_MUL, 1'b1);
        p3_pipeline_regWrite = 1'b1;
        #2;
        got = observed();
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", got); end
        total++;
        if (ex_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", ex_stall); end
        tick();
        tick();
        got = observed();
        total++;
        if (got !== '0 || ex_stall !== 1'b0) begin bad++; $display("FAIL reset_held got=%h stall=%b want=0", got, ex_stall); end
        in_valid = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_add_overflow();
        exp_t e, got;
        rand_bundle(OP_ADD, 1'b1);
        p2_alu_reg_rn = 32'h7FFF_FFFF;
        f_alu_rn_sel  = 2'd0;
        p2_alu_imm    = 32'd1;
        p2_aluSrcB    = 1'b1;
        e = model_bundle();
        tick();
        total++;
        if (p3_alu_aluOut !== 32'h8000_0000 || {p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v} !== 4'b0101 || p3_valid !== 1'b1)
        begin
            bad++;
            $display("FAIL add_ovf got out=%h zncv=%b%b%b%b valid=%b want out=80000000 zncv=0101 valid=1",
                     p3_alu_aluOut, p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v, p3_valid);
        end
        got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL add_ovf_bundle got=%h want=%h", got, e); end
    endtask

    task automatic test_sub_forward();
        rand_bundle(OP_SUB, 1'b1);
        f_alu_rn_sel  = 2'd2;
        fwd_2         = 32'd5;
        f_alu_rm_sel  = 2'd0;
        p2_alu_reg_rm = 32'd3;
        p2_aluSrcB    = 1'b0;
        f_mem_rn_sel  = 2'd0;
        p2_mem_reg_rn = 32'h100;
        p2_mem_imm    = 32'h1C;
        tick();
        total++;
        if (p3_alu_aluOut !== 32'd2 || p3_flag_c !== 1'b1) begin
            bad++;
            $display("FAIL sub_fwd got out=%h c=%b want out=2 c=1", p3_alu_aluOut, p3_flag_c);
        end
        total++;
        if (p3_mem_address !== 32'h11C) begin
            bad++;
            $display("FAIL mem_addr got=%h want=11c", p3_mem_address);
        end
    endtask

    task automatic test_random_alu();
        exp_t e, got;
        logic [3:0] op;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom);
            if (op == OP_MUL) op = 4'd9 + 4'($urandom_range(0, 6));
            rand_bundle(op, ($urandom_range(0, 7) != 0));
            e = model_bundle();
            tick();
            got = observed();
            total++;
            if (got !== e) begin bad++; $display("FAIL rand_alu[%0d] op=%0d got=%h want=%h", i, op, got, e); end
        end
    endtask

    task automatic test_mul();
        exp_t e, got;
        int cyc, stalls, bubble_err;
        for (int k = 0; k < 4; k++) begin
            rand_bundle(OP_MUL, 1'b1);
            if (k == 0) begin
                f_alu_rn_sel  = 2'd0;
                f_alu_rm_sel  = 2'd0;
                p2_aluSrcB    = 1'b0;
                p2_alu_reg_rn = 32'd12345;
                p2_alu_reg_rm = 32'd678;
            end
            e = model_bundle();
            #1;
            stalls     = ex_stall ? 1 : 0;
            bubble_err = 0;
            tick();
            cyc = 1;
            while (!p3_valid && cyc < 60) begin
                if (p3_memRead !== 1'b0 || p3_memWrite !== 1'b0) bubble_err++;
                if (ex_stall) stalls++;
                rand_bundle(4'($urandom), (cyc < 30));
                tick();
                cyc++;
            end
            got = observed();
            total++;
            if (cyc != 33) begin bad++; $display("FAIL mul_latency[%0d] got=%0d want=33", k, cyc); end
            total++;
            if (stalls != 32) begin bad++; $display("FAIL mul_stall_cycles[%0d] got=%0d want=32", k, stalls); end
            total++;
            if (bubble_err != 0) begin bad++; $display("FAIL mul_bubbles[%0d] got=%0d bad bubbles want=0", k, bubble_err); end
            total++;
            if (got !== e) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", k, got, e); end
            if (k == 0) begin
                total++;
                if (p3_alu_aluOut !== 32'd8369910) begin
                    bad++;
                    $display("FAIL mul_12345x678 got=%0d want=8369910", p3_alu_aluOut);
                end
            end
            total++;
            if (ex_stall !== 1'b0) begin bad++; $display("FAIL mul_stall_after got=%b want=0", ex_stall); end
        end
    endtask

    task automatic test_flush();
        exp_t e, got;
        int seen;
        rand_bundle(OP_MUL, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            rand_bundle(OP_ADD, 1'b1);
            tick();
        end
        rand_bundle(OP_ADD, 1'b1);
        EX_flush = 1'b1;
        tick();
        EX_flush = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (p3_valid !== 1'b0 || p3_memRead !== 1'b0 || p3_memWrite !== 1'b0) begin
            bad++;
            $display("FAIL flush_bubble got v/r/w=%b%b%b want=000", p3_valid, p3_memRead, p3_memWrite);
        end
        total++;
        if (ex_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", ex_stall); end
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (p3_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL flush_abort got=%0d late results want=0", seen); end
        rand_bundle(OP_ADD, 1'b1);
        e = model_bundle();
        tick();
        got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL flush_then_add got=%h want=%h", got, e); end

        // Flush must win even when the enable is low.
        rand_bundle(OP_MUL, 1'b1);
        tick();
        p3_pipeline_regWrite = 1'b0;
        EX_flush             = 1'b1;
        tick();
        EX_flush             = 1'b0;
        p3_pipeline_regWrite = 1'b1;
        in_valid             = 1'b0;
        #1;
        total++;
        if (ex_stall !== 1'b0 || p3_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_en_low got stall=%b valid=%b want 0 0", ex_stall, p3_valid);
        end
        tick();
    endtask

    task automatic test_enable_hold();
        exp_t e, got;
        int cyc, hold_err;
        rand_bundle(OP_EOR, 1'b1);
        e = model_bundle();
        tick();
        hold_err = 0;
        p3_pipeline_regWrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_bundle(4'($urandom_range(0, 7)), 1'b1);
            tick();
            got = observed();
            if (got !== e) hold_err++;
        end
        p3_pipeline_regWrite = 1'b1;
        total++;
        if (hold_err != 0) begin bad++; $display("FAIL hold_idle got=%0d changed cycles want=0", hold_err); end

        rand_bundle(OP_MUL, 1'b1);
        e = model_bundle();
        tick();
        cyc      = 1;
        hold_err = 0;
        while (!p3_valid && cyc < 60) begin
            if (cyc >= 12 && cyc < 17) begin
                p3_pipeline_regWrite = 1'b0;
                rand_bundle(4'($urandom), 1'($urandom));
                #1;
                if (ex_stall !== 1'b1 || p3_valid !== 1'b0 || p3_memRead !== 1'b0) hold_err++;
            end else begin
                p3_pipeline_regWrite = 1'b1;
                rand_bundle(4'($urandom), (cyc < 30));
            end
            tick();
            cyc++;
        end
        p3_pipeline_regWrite = 1'b1;
        got = observed();
        total++;
        if (cyc != 38) begin bad++; $display("FAIL hold_mul_latency got=%0d want=38", cyc); end
        total++;
        if (hold_err != 0) begin bad++; $display("FAIL hold_mul_frozen got=%0d bad cycles want=0", hold_err); end
        total++;
        if (got !== e) begin bad++; $display("FAIL hold_mul_result got=%h want=%h", got, e); end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e, got;
        int seen;
        rand_bundle(OP_ORR, 1'b1);
        p2_alu_reg_rn = 32'hA5A5_0001;
        f_alu_rn_sel  = 2'd0;
        tick();
        rand_bundle(OP_MUL, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) tick();
        #3;
        reset = 1'b1;
        #1;
        got = observed();
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_mid_mul got=%h want=0", got); end
        total++;
        if (ex_stall !== 1'b0) begin bad++; $display("FAIL reset_mid_stall got=%b want=0", ex_stall); end
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        seen     = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (p3_valid || ex_stall) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL reset_discard got=%0d active cycles want=0", seen); end
        rand_bundle(OP_ADD, 1'b1);
        e = model_bundle();
        tick();
        got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL reset_then_add got=%h want=%h", got, e); end
    endtask

    initial begin
        reset                = 1'b1;
        p3_pipeline_regWrite = 1'b0;
        EX_flush             = 1'b0;
        rand_bundle(OP_ADD, 1'b0);
        test_reset();
        test_add_overflow();
        test_sub_forward();
        test_random_alu();
        test_mul();
        test_flush();
        test_enable_hold();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
